freq_scan_ctrl: RTL and testbench
=================================

// Module: freq_scan_ctrl
// PURPOSE
//  Sequences one shared probe-frequency counter across NUM_CH probe inputs.
//  - Drives the probe mux select; waits for the synchronised count to settle; then times one gate interval.
//  - Reports each result (count delta over the gate) on a valid/ready stream.
//  - Two request sources: a background round-robin scan over chan_mask, and single-shot host requests.
//  - Host requests have priority whenever the block is idle.
// PARAMETERS
//  NUM_CH    8           probe channels; CW = max(1,$clog2(NUM_CH))
//  CLK_FREQ  12000000    sys_clock frequency, Hz
//  GATE_DIV  10          gate = CLK_FREQ/GATE_DIV cycles (GATE_LEN); result unit = GATE_DIV Hz
//  SETTLE    16          cycles (>=1) waited after a probe_sel change before the start snapshot
// PORTS
//  sys_clock   in   1        system clock, all logic on rising edge
//  sys_resetn  in   1        asynchronous active-low reset
//  enable      in   1        background scan enable
//  chan_mask   in   NUM_CH   channels included in the scan
//  probe_sel   out  CW       probe mux select to the shared counter
//  count_in    in   24       running probe count, already synchronised to sys_clock
//  req_valid   in   1        host single-shot request
//  req_chan    in   CW       requested channel
//  req_ready   out  1        request accepted this cycle
//  res_valid   out  1        result available
//  res_ready   in   1        result consumed
//  res_chan    out  CW       channel of result
//  res_freq    out  24       count_in delta over gate (GATE_DIV Hz units)
//  res_src     out  1        0 = scan, 1 = host request
//  res_err     out  1        1 = host req_chan >= NUM_CH; res_freq = 0
//  busy        out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; last_ch = NUM_CH-1 (first scan picks lowest set bit).
//  FSM: IDLE -> SELECT -> SETTLE -> START -> GATE -> CAPTURE -> OUTPUT -> IDLE.
//  IDLE:
//   - If req_valid: req_ready = 1 (combinational, IDLE only), latch req_chan, src = 1.
//   - Else if enable and |chan_mask: pick next set mask bit after last_ch, wrapping; update last_ch; src = 0.
//   - Else stay in IDLE.
//   - Host request with req_chan >= NUM_CH: accepted; go directly to OUTPUT with res_err = 1, res_freq = 0.
//   - Scan-selected channels and valid host requests go to SELECT.
//  SELECT: probe_sel <= channel; load settle counter SETTLE-1.
//  SETTLE: decrement; at 0 -> START.
//  START: start_cnt <= count_in; load gate counter GATE_LEN-1.
//  GATE: decrement; at 0 -> CAPTURE.
//  CAPTURE: res_freq <= count_in - start_cnt (mod 2^24); set res_chan and res_src; res_err = 0.
//  OUTPUT:
//   - res_valid = 1; res_* held stable until res_valid && res_ready.
//   - On handshake: res_valid drops next cycle and the FSM returns to IDLE.
//  Latency: the accept cycle in IDLE is cycle 0; res_valid rises at cycle SETTLE + GATE_LEN + 4.
//   - Error requests: res_valid rises at cycle 1.
//  probe_sel holds its last value outside SELECT..CAPTURE.
//  Host requests arriving mid-measurement wait, with req_ready = 0, until the next IDLE.
//  Host requests win over the scan; host requests do not update last_ch.
//  enable or chan_mask changes mid-measurement take effect at the next IDLE; the current measurement completes.
//  Deltas wrap at 2^24 (no saturation).
//  A count_in wrap within the gate is handled by modulo subtraction.
//  Async reset mid-operation aborts immediately to reset values; no partial result is emitted.
// TESTING (NUM_CH=4, CLK_FREQ=1000, GATE_DIV=10 -> GATE_LEN=100, SETTLE=4; count_in model adds rate[probe_sel] per cycle)
//  Scan, rate = {1,2,3,4}, mask = 4'b1111, res_ready = 1 -> results ch0..3 = 100,200,300,400, res_src = 0, then wrap to ch0.
//  mask = 4'b1010 -> channel order 1,3,1,3; mask = 0 with enable = 1 -> busy stays 0, no results.
//  Host req ch2 while idle -> req_ready same cycle; res_valid at cycle 108; res_freq = 300, res_src = 1; next scan channel unchanged.
//  req_chan = 3 with NUM_CH = 3 -> res_err = 1, res_freq = 0, res_valid at cycle 1.
//  Host req during a scan gate -> req_ready held 0 until IDLE; res_ready = 0 for 20 cycles -> res_* stable, no new gate starts.
//  count_in preset to 24'hFFFFC0, rate 1 -> res_freq = 100; sys_resetn pulsed low mid-GATE -> outputs 0, res_valid never asserted.

Source files
------------

// File: rtl/freq_scan_ctrl.sv
// Time-shares one synchronised probe counter across NUM_CH inputs. A round-robin
// background scan and single-shot host requests feed a settle/gate measurement FSM.
module freq_scan_ctrl #(
   parameter int NUM_CH   = 8,
   parameter int CLK_FREQ = 12000000,
   parameter int GATE_DIV = 10,
   parameter int SETTLE   = 16,
   localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              sys_clock,
   input  logic              sys_resetn,
   input  logic              enable,
   input  logic [NUM_CH-1:0] chan_mask,
   output logic [CW-1:0]     probe_sel,
   input  logic [23:0]       count_in,
   input  logic              req_valid,
   input  logic [CW-1:0]     req_chan,
   output logic              req_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CW-1:0]     res_chan,
   output logic [23:0]       res_freq,
   output logic              res_src,
   output logic              res_err,
   output logic              busy
);

   localparam int GATE_LEN = CLK_FREQ / GATE_DIV;
   localparam int CNT_MAX  = (GATE_LEN > SETTLE) ? GATE_LEN : SETTLE;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_START   = 3'd3,
      ST_GATE    = 3'd4,
      ST_CAPTURE = 3'd5,
      ST_OUTPUT  = 3'd6
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CW-1:0]    last_ch_r;
   logic [CW-1:0]    chan_r;
   logic             src_r;
   logic [23:0]      start_cnt_r;
   logic [23:0]      end_cnt_r;
   logic [CW-1:0]    probe_sel_r;
   logic [CW-1:0]    res_chan_r;
   logic [23:0]      res_freq_r;
   logic             res_valid_r;
   logic             res_src_r;
   logic             res_err_r;
   logic             busy_r;

   logic [CW:0]      scan_sum_s;
   logic [CW-1:0]    scan_idx_s;
   logic [CW-1:0]    scan_ch_s;
   logic             scan_hit_s;
   logic             req_err_s;
   logic             host_take_s;
   logic             scan_take_s;
   logic             cnt_zero_s;

   // Round-robin pick: walk downward so the nearest set bit after last_ch is written last.
   always_comb begin
      scan_sum_s = {(CW+1){1'b0}};
      scan_idx_s = {CW{1'b0}};
      scan_ch_s  = {CW{1'b0}};
      scan_hit_s = |chan_mask;
      for (int i = NUM_CH; i >= 1; i--) begin
         scan_sum_s = {1'b0, last_ch_r} + (CW+1)'(i);
         scan_idx_s = CW'((scan_sum_s >= (CW+1)'(NUM_CH)) ? (scan_sum_s - (CW+1)'(NUM_CH)) : scan_sum_s);
         scan_ch_s  = chan_mask[scan_idx_s] ? scan_idx_s : scan_ch_s;
      end
   end

   assign req_err_s   = ({1'b0, req_chan} >= (CW+1)'(NUM_CH));
   assign host_take_s = (state_r == ST_IDLE) && req_valid;
   assign scan_take_s = (state_r == ST_IDLE) && !req_valid && enable && scan_hit_s;
   assign cnt_zero_s  = (cnt_r == {CNT_W{1'b0}});

   // Next-state decode for the measurement sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (host_take_s) begin
               if (req_err_s) begin
                  state_nxt_s = ST_OUTPUT;
               end else begin
                  state_nxt_s = ST_SELECT;
               end
            end else if (scan_take_s) begin
               state_nxt_s = ST_SELECT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SELECT:  state_nxt_s = ST_SETTLE;
         ST_SETTLE:  state_nxt_s = cnt_zero_s ? ST_START : ST_SETTLE;
         ST_START:   state_nxt_s = ST_GATE;
         ST_GATE:    state_nxt_s = cnt_zero_s ? ST_CAPTURE : ST_GATE;
         ST_CAPTURE: state_nxt_s = ST_OUTPUT;
         ST_OUTPUT:  state_nxt_s = (res_valid_r && res_ready) ? ST_IDLE : ST_OUTPUT;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath: channel choice, counters, snapshots and the result holding registers.
   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         cnt_r       <= {CNT_W{1'b0}};
         last_ch_r   <= CW'(NUM_CH - 1);
         chan_r      <= {CW{1'b0}};
         src_r       <= 1'b0;
         start_cnt_r <= 24'd0;
         end_cnt_r   <= 24'd0;
         probe_sel_r <= {CW{1'b0}};
         res_chan_r  <= {CW{1'b0}};
         res_freq_r  <= 24'd0;
         res_valid_r <= 1'b0;
         res_src_r   <= 1'b0;
         res_err_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (host_take_s) begin
                  chan_r <= req_chan;
                  src_r  <= 1'b1;
                  if (req_err_s) begin
                     res_chan_r  <= req_chan;
                     res_freq_r  <= 24'd0;
                     res_src_r   <= 1'b1;
                     res_err_r   <= 1'b1;
                     res_valid_r <= 1'b1;
                  end
               end else if (scan_take_s) begin
                  chan_r    <= scan_ch_s;
                  last_ch_r <= scan_ch_s;
                  src_r     <= 1'b0;
               end
            end
            ST_SELECT: begin
               probe_sel_r <= chan_r;
               cnt_r       <= CNT_W'(SETTLE - 1);
            end
            ST_SETTLE: begin
               if (!cnt_zero_s) begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_START: begin
               start_cnt_r <= count_in;
               cnt_r       <= CNT_W'(GATE_LEN - 1);
            end
            ST_GATE: begin
               // End snapshot on the last gate cycle keeps the window exactly GATE_LEN edges.
               if (cnt_zero_s) begin
                  end_cnt_r <= count_in;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_CAPTURE: begin
               res_freq_r  <= end_cnt_r - start_cnt_r;
               res_chan_r  <= chan_r;
               res_src_r   <= src_r;
               res_err_r   <= 1'b0;
               res_valid_r <= 1'b1;
            end
            ST_OUTPUT: begin
               if (res_ready) begin
                  res_valid_r <= 1'b0;
               end
            end
            default: begin
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = sys_resetn & host_take_s;
   assign probe_sel = probe_sel_r;
   assign res_valid = res_valid_r;
   assign res_chan  = res_chan_r;
   assign res_freq  = res_freq_r;
   assign res_src   = res_src_r;
   assign res_err   = res_err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Randomised directed bench for freq_scan_ctrl; expectations come from a rate*gate
// arithmetic model and a modulo round-robin model of the scan order.
module tb_freq_scan_ctrl;

   localparam int GATE_LEN = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [3:0]  chan_mask;
   logic [1:0]  probe_sel;
   logic [23:0] count;
   logic        req_valid;
   logic [1:0]  req_chan;
   logic        req_ready;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_chan;
   logic [23:0] res_freq;
   logic        res_src;
   logic        res_err;
   logic        busy;

   logic        enable3;
   logic [2:0]  chan_mask3;
   logic [1:0]  probe_sel3;
   logic [23:0] count3;
   logic        req_valid3;
   logic [1:0]  req_chan3;
   logic        req_ready3;
   logic        res_valid3;
   logic        res_ready3;
   logic [1:0]  res_chan3;
   logic [23:0] res_freq3;
   logic        res_src3;
   logic        res_err3;
   logic        busy3;

   int          rate [4];
   logic        preset_req;
   int          n_cmp = 0;
   int          n_err = 0;
   int          model_last;
   int          ch;
   int          cyc;
   logic        bad;
   logic [28:0] snap;

   freq_scan_ctrl #(.NUM_CH(4), .CLK_FREQ(1000), .GATE_DIV(10), .SETTLE(4)) dut (
      .sys_clock(clk), .sys_resetn(rst_n), .enable(enable), .chan_mask(chan_mask),
      .probe_sel(probe_sel), .count_in(count), .req_valid(req_valid), .req_chan(req_chan),
      .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
      .res_freq(res_freq), .res_src(res_src), .res_err(res_err), .busy(busy)
   );

   freq_scan_ctrl #(.NUM_CH(3), .CLK_FREQ(1000), .GATE_DIV(10), .SETTLE(4)) dut3 (
      .sys_clock(clk), .sys_resetn(rst_n), .enable(enable3), .chan_mask(chan_mask3),
      .probe_sel(probe_sel3), .count_in(count3), .req_valid(req_valid3), .req_chan(req_chan3),
      .req_ready(req_ready3), .res_valid(res_valid3), .res_ready(res_ready3), .res_chan(res_chan3),
      .res_freq(res_freq3), .res_src(res_src3), .res_err(res_err3), .busy(busy3)
   );

   always #5 clk = ~clk;

   // Probe counter model: each selected probe advances by its rate every cycle.
   always @(posedge clk) begin
      if (preset_req) begin
         count <= 24'hFFFFC0;
      end else begin
         count <= count + 24'(rate[probe_sel]);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int next_scan(input int last, input logic [3:0] m);
      for (int k = 1; k <= 4; k++) begin
         int c = (last + k) % 4;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [23:0] exp_freq(input int c);
      longint p = longint'(rate[c]) * GATE_LEN;
      return p[23:0];
   endfunction

   task automatic wait_valid(input string tag);
      int n = 0;
      while (res_valid !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".timeout"}, {63'd0, res_valid}, 64'd1);
   endtask

   task automatic check_fields(input string tag, input int c, input logic [23:0] f,
                               input logic s, input logic e);
      check({tag, ".chan"}, {62'd0, res_chan}, 64'(c));
      check({tag, ".freq"}, {40'd0, res_freq}, {40'd0, f});
      check({tag, ".src"},  {63'd0, res_src},  {63'd0, s});
      check({tag, ".err"},  {63'd0, res_err},  {63'd0, e});
   endtask

   task automatic do_result(input string tag, input int c, input logic [23:0] f,
                            input logic s, input logic e);
      wait_valid(tag);
      check_fields(tag, c, f, s, e);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, ".drop"}, {63'd0, res_valid}, 64'd0);
   endtask

   task automatic scan_one(input string tag);
      ch = next_scan(model_last, chan_mask);
      model_last = ch;
      do_result(tag, ch, exp_freq(ch), 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; chan_mask = 4'd0; req_valid = 1'b0; req_chan = 2'd0;
      res_ready = 1'b0; preset_req = 1'b0; count = 24'd0;
      enable3 = 1'b0; chan_mask3 = 3'd0; count3 = 24'd0; req_valid3 = 1'b0;
      req_chan3 = 2'd0; res_ready3 = 1'b0;
      rate[0] = 1; rate[1] = 2; rate[2] = 3; rate[3] = 4;
      model_last = 3;
      repeat (3) @(negedge clk);
      check("reset.outs", {res_valid, busy, req_ready, res_src, res_err, probe_sel, res_chan, res_freq}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset.idle", {busy, res_valid, busy3, res_valid3}, 64'd0);

      // Full mask scan, then 4'b1010 order 1,3,1,3
      chan_mask = 4'b1111; enable = 1'b1;
      for (int k = 0; k < 5; k++) scan_one("scan_all");
      chan_mask = 4'b1010;
      for (int k = 0; k < 4; k++) scan_one("scan_1010");
      check("scan_1010.last", 64'(model_last), 64'd3);

      chan_mask = 4'b0000;
      bad = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (busy !== 1'b0 || res_valid !== 1'b0) bad = 1'b1;
      end
      check("mask0.quiet", {63'd0, bad}, 64'd0);
      enable = 1'b0; chan_mask = 4'b1111;

      // Host request latency and scan pointer preservation
      req_valid = 1'b1; req_chan = 2'd2;
      #1 check("host.ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      while (res_valid !== 1'b1 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check("host.latency", 64'(cyc), 64'd108);
      do_result("host", 2, 24'd300, 1'b1, 1'b0);
      enable = 1'b1;
      scan_one("after_host");
      enable = 1'b0;

      // Out-of-range host channel on the 3-channel instance
      req_valid3 = 1'b1; req_chan3 = 2'd3;
      #1 check("err.ready", {63'd0, req_ready3}, 64'd1);
      @(negedge clk);
      req_valid3 = 1'b0;
      check("err.valid", {63'd0, res_valid3}, 64'd1);
      check("err.fields", {res_chan3, res_freq3, res_src3, res_err3, busy3}, {35'd0, 2'd3, 24'd0, 3'b111});
      res_ready3 = 1'b1;
      @(negedge clk);
      res_ready3 = 1'b0;
      check("err.done", {res_valid3, busy3}, 64'd0);

      // Host request during a scan gate, plus 20-cycle result back-pressure
      for (int i = 0; i < 4; i++) rate[i] = $urandom_range(1, 5000);
      enable = 1'b1;
      repeat (40) @(negedge clk);
      req_valid = 1'b1; req_chan = 2'd3;
      bad = 1'b0; cyc = 0;
      while (res_valid !== 1'b1 && cyc < 300) begin
         #1 if (req_ready !== 1'b0) bad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      check("stall.ready_low", {63'd0, bad}, 64'd0);
      ch = next_scan(model_last, chan_mask);
      model_last = ch;
      check_fields("stall.scan", ch, exp_freq(ch), 1'b0, 1'b0);
      snap = {res_chan, res_freq, res_src, res_err, probe_sel};
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0 ||
             {res_chan, res_freq, res_src, res_err, probe_sel} !== snap) bad = 1'b1;
      end
      check("stall.hold", {63'd0, bad}, 64'd0);
      do_result("stall.scan2", ch, exp_freq(ch), 1'b0, 1'b0);
      check("stall.host_wins", {63'd0, req_ready}, 64'd1);
      enable = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      do_result("stall.host", 3, exp_freq(3), 1'b1, 1'b0);
      enable = 1'b1;
      scan_one("stall.resume");
      enable = 1'b0;

      // Random rates and masks
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) rate[i] = $urandom_range(1, 200000);
         chan_mask = 4'($urandom_range(1, 15));
         enable = 1'b1;
         for (int k = 0; k < 4; k++) scan_one("rand");
      end
      enable = 1'b0;

      // Counter wrap inside the gate
      for (int i = 0; i < 4; i++) rate[i] = 1;
      preset_req = 1'b1;
      @(negedge clk);
      preset_req = 1'b0; req_valid = 1'b1; req_chan = 2'd1;
      @(negedge clk);
      req_valid = 1'b0;
      do_result("wrap", 1, 24'd100, 1'b1, 1'b0);

      // Reset during the gate aborts without a result
      rate[2] = $urandom_range(1, 5000);
      req_valid = 1'b1; req_chan = 2'd2;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (50) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("abort.outs", {res_valid, busy, req_ready, res_src, res_err, probe_sel, res_chan, res_freq}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_last = 3;
      bad = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      check("abort.silent", {63'd0, bad}, 64'd0);
      chan_mask = 4'b1111; enable = 1'b1;
      scan_one("abort.rescan");
      enable = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
